ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send direction of the keyboard PS/2 link already decoded by the keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using the standard request-to-send sequence.
- Drives open-collector clock/data enables; the toplevel ties each line low when its enable is 1, else Z.
- Runs on clkvga (25 MHz) beside the keyboard block.

Parameters:
- INHIBIT_CYCLES, 2500: clocks that ps2_clk is held low for request-to-send (100 us at 25 MHz).
- TIMEOUT_CYCLES, 375000: max clocks between device events before abort (15 ms).
- FILTER_LEN, 4: consecutive equal synchronized samples needed to accept a new ps2_clk level.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: request; accepted when tx_valid && tx_ready on a clk edge.
- tx_ready, out, 1: high only in IDLE.
- ps2_clk_in, in, 1: raw PS/2 clock line.
- ps2_data_in, in, 1: raw PS/2 data line.
- ps2_clk_oe, out, 1: 1 = pull clock low.
- ps2_data_oe, out, 1: 1 = pull data low.
- busy, out, 1: high in every state except IDLE.
- tx_done, out, 1: one-cycle pulse, device ACKed.
- tx_error, out, 1: one-cycle pulse, NACK or timeout.

Behaviour:
- Reset (synchronous, active-high) values:
  - State IDLE; tx_ready=1 from the first clock after rst deasserts; tx_ready=0 while rst=1.
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0.
  - Shift register, bit counter and timers all 0.
- rst asserted mid-transfer: both lines released on the next edge; no tx_done or tx_error pulse.
- Input path: ps2_clk_in and ps2_data_in pass through a 2-FF synchronizer each.
- The filtered clock level changes only after FILTER_LEN equal samples. A fall = filtered level 1→0.
- Fall-to-action latency: at most 2+FILTER_LEN+1 clocks.
- Accept: latch {odd parity, tx_data}, where parity = ~^tx_data. Go to INHIBIT.
- INHIBIT:
  - clk_oe=1, data_oe=0 for INHIBIT_CYCLES clocks.
  - Last cycle: data_oe=1, which is the start bit.
  - Next state: START.
- START:
  - clk_oe=0, data_oe stays 1; bitcnt=0.
  - Start the timeout timer; go to SEND.
- SEND:
  - On each fall, drive bit bitcnt and increment bitcnt.
  - bitcnt 0..7 drive data bits LSB first; bitcnt 8 drives parity; bitcnt 9 drives stop (data_oe=0).
  - Driving bit value b means data_oe=~b.
  - After the stop bit is driven, go to ACK.
- ACK:
  - On the next fall, sample synchronized data.
  - Data 0: ACK, go to WAIT_IDLE.
  - Data 1: NACK, pulse tx_error, go to IDLE.
- WAIT_IDLE:
  - Wait until filtered clk=1 and synchronized data=1.
  - Then pulse tx_done and go to IDLE; tx_ready returns the following cycle.
- Timeout:
  - The counter clears on entry to START and on every fall.
  - In SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines, pulses tx_error and returns to IDLE.
  - The counter saturates and does not wrap.
- tx_done and tx_error are never high together and are never high in the same cycle as tx_ready.
- tx_valid while busy is ignored: no queuing and no overwrite of the latched byte.
- Glitches on ps2_clk shorter than FILTER_LEN clocks produce no fall and do not advance bitcnt.
- Faults (ps2_data_in stuck low, no clock from device): terminate via timeout only; no other error path.

Test Plan:
- INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, FILTER_LEN=4; the device model clocks with a 16-clock period. Send 0xED, device ACKs:
  - ps2_clk_oe high for 20 cycles.
  - Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - One tx_done pulse, no tx_error.
- Send 0xF4 → device samples bits 0,0,1,0,1,1,1,1, parity=0; ACK → tx_done.
- Send 0xFF with the device answering NACK (data high at the 11th fall) → tx_error single pulse, tx_done=0, tx_ready=1 afterwards.
- Device stops clocking after 4 falls → tx_error exactly 200 clocks after the last fall; both oe=0; next 0x00 transfer succeeds with parity=1.
- Mid-SEND checks:
  - Assert rst mid-SEND: oe outputs and busy are 0 the next cycle, with no pulses.
  - Inject a 2-clock low glitch on ps2_clk: the bit sequence is unchanged.
- Pulse tx_valid with 0x55 while busy during a 0xED send → only 0xED is transmitted; tx_ready=0 throughout the transfer.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shifted out on
// device clock falls, ACK check, and a device-silence timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_filt_q, clk_filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d, ready_q, ready_d;
  logic             clk_s, data_s, fall, timeout;

  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  assign timer_inc = (timer_q == TMR_W'(TMR_MAX)) ? timer_q : timer_q + TMR_W'(1);
  assign timeout   = (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1));

  // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    fall       = 1'b0;
    if (clk_s != clk_filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s;
        fall       = clk_filt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    timer_d   = timer_inc;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d   = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          shift_d  = {~^tx_data, tx_data};
          bitcnt_d = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (timer_inc >= TMR_W'(INHIBIT_CYCLES)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = S_START;
        end else begin
          data_oe_d = (timer_inc == TMR_W'(INHIBIT_CYCLES - 1));
        end
      end
      S_START: begin
        bitcnt_d = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else if (fall) begin
          // Shifting in ones makes the tenth bit the stop bit.
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          timer_d   = '0;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else if (fall) begin
          timer_d = '0;
          if (!data_s) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_filt_q && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) && !done_d && !error_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      flt_cnt_q   <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      timer_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_filt_q  <= clk_filt_d;
      flt_cnt_q   <= flt_cnt_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      timer_q     <= timer_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ready_q     <= ready_d;
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 device model, vector table,
// random bytes against a frame model, and timeout/reset/glitch/busy sequences.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TO  = 200;
  localparam int unsigned FL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ready_busy_cnt = 0;
  int last_fall_cyc = 0;

  // Wired-AND lines: low when either side pulls.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done) done_cnt = done_cnt + 1;
      if (tx_error) err_cnt = err_cnt + 1;
      if (tx_done || tx_error) begin
        check("pulse_exclusive", int'(tx_done && tx_error), 0);
        check("pulse_vs_ready", int'(tx_ready), 0);
      end
      if (busy && tx_ready) ready_busy_cnt = ready_busy_cnt + 1;
    end
  end

  // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones = ones + int'(d[k]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic wait_ready(input string name);
    int g;
    g = 0;
    while (!tx_ready && g < 400) begin
      tick();
      g++;
    end
    check(name, int'(tx_ready), 1);
  endtask

  task automatic start_req(input logic [7:0] d);
    wait_ready("ready_before_req");
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Device: measures the inhibit, then clocks n_falls falls at a 16-clock period.
  task automatic run_device(input int n_falls, input bit ack, input bit glitch,
                            input bit poke, output logic [10:0] bits);
    int g;
    int cnt;
    bits = 11'h7FF;
    g = 0;
    while (!ps2_clk_oe && g < 50) begin
      tick();
      g++;
    end
    check("inhibit_start", int'(ps2_clk_oe), 1);
    cnt = 0;
    while (ps2_clk_oe && cnt < 300) begin
      cnt++;
      tick();
    end
    check("inhibit_len", cnt, int'(INH));
    bits[0] = ps2_data_in;
    repeat (12) tick();
    for (int i = 1; i <= n_falls; i++) begin
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (8) tick();
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i] = ps2_data_in;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (i == 11) dev_data_low = 1'b0;
      if (poke && i == 2) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        check("ready_during_poke", int'(tx_ready), 0);
        tx_valid = 1'b0;
        repeat (7) tick();
      end else begin
        repeat (8) tick();
      end
      if (glitch && i == 3) begin
        dev_clk_low = 1'b1;
        repeat (2) tick();
        dev_clk_low = 1'b0;
        repeat (8) tick();
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    bit         parity;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [10:0] bits;
    logic [10:0] exp;
    logic [7:0]  d;
    bit          ack;
    int          d0, e0, rb0, g, oe_seen;

    vecs[0] = '{data: 8'hED, ack: 1'b1, glitch: 1'b0, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'hF4, ack: 1'b1, glitch: 1'b0, parity: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'hFF, ack: 1'b0, glitch: 1'b0, parity: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{data: 8'hED, ack: 1'b1, glitch: 1'b1, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'h55, ack: 1'b1, glitch: 1'b0, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

    // Reset state
    repeat (3) tick();
    check("rst_ready", int'(tx_ready), 0);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'(tx_done | tx_error), 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", int'(tx_ready), 1);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      start_req(vecs[i].data);
      run_device(11, vecs[i].ack, vecs[i].glitch, 1'b0, bits);
      wait_ready($sformatf("v%0d_ready_after", i));
      exp = {1'b1, vecs[i].parity, vecs[i].data, 1'b0};
      check($sformatf("v%0d_frame", i), int'(bits), int'(exp));
      check($sformatf("v%0d_done", i), done_cnt - d0, int'(vecs[i].exp_done));
      check($sformatf("v%0d_error", i), err_cnt - e0, int'(vecs[i].exp_err));
    end

    for (int i = 0; i < 8; i++) begin
      d   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      d0  = done_cnt;
      e0  = err_cnt;
      start_req(d);
      run_device(11, ack, 1'b0, 1'b0, bits);
      wait_ready($sformatf("r%0d_ready_after", i));
      check($sformatf("r%0d_frame", i), int'(bits), int'(model_frame(d)));
      check($sformatf("r%0d_done", i), done_cnt - d0, ack ? 1 : 0);
      check($sformatf("r%0d_error", i), err_cnt - e0, ack ? 0 : 1);
    end

    // Device goes silent after four falls
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'h3C);
    run_device(4, 1'b0, 1'b0, 1'b0, bits);
    g = 0;
    while (!tx_error && g < 400) begin
      tick();
      g++;
    end
    check("timeout_seen", int'(tx_error), 1);
    check("timeout_latency", cyc - last_fall_cyc, int'(2 + FL + TO));
    check("timeout_clk_oe", int'(ps2_clk_oe), 0);
    check("timeout_data_oe", int'(ps2_data_oe), 0);
    wait_ready("timeout_ready_after");
    check("timeout_error_count", err_cnt - e0, 1);
    check("timeout_done_count", done_cnt - d0, 0);
    d0 = done_cnt;
    start_req(8'h00);
    run_device(11, 1'b1, 1'b0, 1'b0, bits);
    wait_ready("zero_ready_after");
    check("zero_frame", int'(bits), int'(model_frame(8'h00)));
    check("zero_parity", int'(bits[9]), 1);
    check("zero_done", done_cnt - d0, 1);

    // Reset in the middle of SEND
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hA7);
    run_device(5, 1'b0, 1'b0, 1'b0, bits);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("midrst_clk_oe", int'(ps2_clk_oe), 0);
    check("midrst_data_oe", int'(ps2_data_oe), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(tx_ready), 0);
    check("midrst_pulses", int'(tx_done | tx_error), 0);
    rst = 1'b0;
    tick();
    check("midrst_ready_after", int'(tx_ready), 1);
    repeat (20) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_error", err_cnt - e0, 0);

    // Request while busy is dropped
    d0  = done_cnt;
    rb0 = ready_busy_cnt;
    start_req(8'hED);
    run_device(11, 1'b1, 1'b0, 1'b1, bits);
    wait_ready("poke_ready_after");
    check("poke_frame", int'(bits), int'(model_frame(8'hED)));
    check("poke_done", done_cnt - d0, 1);
    oe_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ps2_clk_oe || busy) oe_seen = 1;
    end
    check("poke_no_requeue", oe_seen, 0);
    check("poke_ready_while_busy", ready_busy_cnt - rb0, 0);
    check("ready_busy_overall", ready_busy_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
